// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: shared types and constants for the TFF counter sequencer.
//   tff_ctrl_state_t : sequencer state encoding (IDLE / RUN / DONE)
//   DIR_UP/DIR_DOWN  : encoding of the dir input
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } tff_ctrl_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// tff_cell: single toggle flip-flop, async active-low reset to 0.
//   clk   in : clock
//   rst_n in : async reset, active low
//   t     in : toggle enable, q flips on rising edge when 1
//   q     out: stored bit
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else if (t) q <= ~q;
    end

endmodule

// File: rtl/tff_counter_ctrl.sv
// tff_counter_ctrl: sequencer driving a bank of toggle flops as an up/down
// modulo counter with a start/stop/done handshake.
//   clk, rst_n   : clock, async active-low reset
//   start        : request a run (sampled in IDLE) with dir / limit
//   stop         : abort current run (sampled in RUN)
//   count        : bank outputs
//   t_vec        : toggle enables into the bank (combinational)
//   busy / done  : RUN indicator / one-cycle completion pulse
// Optional build macro TFF_CTRL_AUTORELOAD_EN: on reaching the target the
// counter reloads its initial value and keeps running, pulsing done.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    tff_ctrl_state_t  state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic [WIDTH-1:0] start_init;
    logic [WIDTH-1:0] run_init;
    logic [WIDTH-1:0] run_target;
    logic [WIDTH-1:0] step_vec;
    logic             at_target;

    // Init for a new run comes from the live inputs; once running, from the
    // latched copies so mid-run dir/limit changes are ignored.
    assign start_init = (dir == DIR_DOWN) ? limit : '0;
    assign run_init   = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign run_target = (dir_q == DIR_DOWN) ? '0 : limit_q;
    assign at_target  = (count == run_target);

    // Ripple toggle enables: bit i flips when all lower bits are 1 (up)
    // or all lower bits are 0 (down).
    always_comb begin
        logic all_one;
        logic all_zero;
        step_vec    = '0;
        step_vec[0] = 1'b1;
        all_one     = count[0];
        all_zero    = ~count[0];
        for (int i = 1; i < WIDTH; i++) begin
            step_vec[i] = (dir_q == DIR_DOWN) ? all_zero : all_one;
            all_one     = all_one & count[i];
            all_zero    = all_zero & ~count[i];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    limit_d = limit;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (at_target) begin
`ifdef TFF_CTRL_AUTORELOAD_EN
                    state_d = RUN;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        t_vec = '0;
        busy  = (state_q == RUN);
        done  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                // The bank can only toggle, so loading means flipping the
                // bits that differ from the init value.
                if (start) t_vec = count ^ start_init;
            end
            RUN: begin
                if (!stop) begin
                    if (at_target) begin
`ifdef TFF_CTRL_AUTORELOAD_EN
                        t_vec = count ^ run_init;
                        done  = 1'b1;
`endif
                    end else begin
                        t_vec = step_vec;
                    end
                end
            end
            default: t_vec = '0;
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t_vec[g]),
            .q     (count[g])
        );
    end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
module tb_tff_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;

    int n_chk = 0;
    int n_err = 0;

    tff_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dir   (dir),
        .limit (limit),
        .stop  (stop),
        .count (count),
        .t_vec (t_vec),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        limit = '0;
        stop  = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_tvec",  t_vec, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        rst_n = 1'b1;
        tick();

`ifndef TFF_CTRL_AUTORELOAD_EN
        // Up run to 5
        start = 1'b1; dir = 1'b0; limit = 4'd5;
        tick();                       // E0
        start = 1'b0;
        chk("up_e0_count", count, 0);
        chk("up_e0_busy",  busy,  1);
        for (int k = 1; k <= 5; k++) begin
            if (count == 4'd3) chk("up_tvec_3", t_vec, 4'b0111);
            tick();
            chk($sformatf("up_count_%0d", k), count, k);
            chk("up_busy", busy, 1);
            chk("up_nodone", done, 0);
        end
        tick();                       // E6
        chk("up_done",     done,  1);
        chk("up_busy_e6",  busy,  0);
        chk("up_hold",     count, 5);
        chk("up_tvec_dn",  t_vec, 0);
        tick();                       // E7
        chk("up_done_off", done,  0);
        chk("up_idle",     busy,  0);

        // Down run from 12; loads by toggling 5 ^ 12
        start = 1'b1; dir = 1'b1; limit = 4'd12;
        #1;
        chk("dn_load_tvec", t_vec, 4'b1001);
        tick();
        start = 1'b0;
        chk("dn_e0_count", count, 12);
        for (int k = 11; k >= 0; k--) begin
            if (count == 4'd8) chk("dn_tvec_8", t_vec, 4'b1111);
            tick();
            chk($sformatf("dn_count_%0d", k), count, k);
            chk("dn_nodone", done, 0);
        end
        tick();
        chk("dn_done",     done, 1);
        tick();
        chk("dn_done_off", done, 0);
        chk("dn_count_z",  count, 0);

        // Stop at 3 of an up run to 7, with start asserted alongside
        start = 1'b1; dir = 1'b0; limit = 4'd7;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("st_count3", count, 3);
        stop = 1'b1; start = 1'b1; limit = 4'd1;
        #1;
        chk("st_tvec", t_vec, 0);
        tick();
        stop = 1'b0; start = 1'b0;
        chk("st_busy",  busy,  0);
        chk("st_hold",  count, 3);
        chk("st_done",  done,  0);
        tick();
        chk("st_busy2", busy,  0);
        chk("st_hold2", count, 3);
        chk("st_done2", done,  0);

        // limit = 0: load from 3 back to 0, done after E1
        start = 1'b1; dir = 1'b0; limit = 4'd0;
        #1;
        chk("l0_load_tvec", t_vec, 4'b0011);
        tick();
        start = 1'b0;
        chk("l0_count", count, 0);
        chk("l0_busy",  busy,  1);
        tick();
        chk("l0_done",  done,  1);
        chk("l0_busy1", busy,  0);
        tick();
        chk("l0_done_off", done, 0);

        // Full range up to 15, no wrap
        start = 1'b1; dir = 1'b0; limit = 4'd15;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (count == 4'd7) chk("fr_tvec_7", t_vec, 4'b1111);
            tick();
            chk($sformatf("fr_count_%0d", k), count, k);
        end
        tick();
        chk("fr_done",  done,  1);
        chk("fr_count", count, 15);
        tick();
        chk("fr_idle",  busy,  0);
`endif

        // Reset mid-run at count 5 of an up run to 9 (count is 15 or 0 here)
        start = 1'b1; dir = 1'b0; limit = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mr_count5", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_count", count, 0);
        chk("mr_busy",  busy,  0);
        chk("mr_done",  done,  0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mr_idle",  busy,  0);

`ifndef TFF_CTRL_AUTORELOAD_EN
        start = 1'b1; dir = 1'b0; limit = 4'd2;
        tick();
        start = 1'b0;
        chk("ma_busy", busy, 1);
        tick(); chk("ma_c1", count, 1);
        tick(); chk("ma_c2", count, 2);
        tick(); chk("ma_done", done, 1);
`else
        // Auto-reload: up to 2, repeats 0,1,2 with done on the 2 cycle
        start = 1'b1; dir = 1'b0; limit = 4'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("ar_count_%0d", k), count, k % 3);
            chk("ar_done", done, (k % 3) == 2);
            chk("ar_busy", busy, 1);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
